demux_dispatch_ctrl: RTL and testbench
======================================

Name: demux_dispatch_ctrl

Overview:
- Sequences a 1-to-4 demux datapath: accepts one input stream and delivers each word to one of four consumer channels over valid/ready handshakes.
- Two routing modes: addressed, where the destination comes from the in_dest field, and round-robin, where the block schedules the next free channel.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four downstream units that share that producer.

Parameters:
- DW, 8, data word width in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = addressed routing, 1 = round-robin routing.
- in_valid  input  1  producer word valid.
- in_ready  output  1  block can accept the word this cycle; combinational.
- in_data  input  DW  producer data.
- in_dest  input  2  destination channel 0..3; used only when mode=0.
- out_valid  output  4  per-channel valid; bit k belongs to channel k.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  4*DW  packed channel data; channel k occupies bits [k*DW +: DW].
- rr_ptr  output  2  round-robin search start pointer.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, rr_ptr=0, busy=0. All state is held while rst_n=0. Any word held in a slot at reset assertion is discarded.
- Slot k is "available" when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 (draining this cycle).
- Target selection, mode=0: target = in_dest. in_ready = available[in_dest].
- Target selection, mode=1: target = first available channel searching rr_ptr, rr_ptr+1, ... mod 4. in_ready = OR of available.
- in_ready must not depend on in_valid. In mode 0 it may depend on in_dest.
- Accept occurs when in_valid & in_ready. On the next edge:
  - slot[target] <= in_data and out_valid[target] <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Round-robin pointer:
  - In mode 1, on accept, rr_ptr <= target+1 (mod 4, wraps 3->0).
  - rr_ptr never changes in mode 0 or on a cycle with no accept.
  - mode may change on any cycle. The new mode applies combinationally. rr_ptr is preserved across mode changes.
- Drain: when out_valid[k] & out_ready[k] and channel k is not loaded this cycle, out_valid[k] <= 0. out_data[k] keeps its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one, out_valid[k] stays 1. This gives full throughput of 1 word per cycle per channel.
- Stall rule: while out_valid[k]=1 and out_ready[k]=0, out_data[k] and out_valid[k] stay stable.
- At most one channel is loaded per cycle. Any number of channels may drain in the same cycle.
- All four slots full with no out_ready: in_ready=0 in both modes, no state change.
- in_valid=1 with in_ready=0: no accept, no pointer movement. The producer must hold the word.
- busy is registered-equivalent: the OR of the current out_valid bits.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high, all out_ready=0 -> out_valid=0000, rr_ptr=0, in_ready=1 in both modes. Asserting rst_n mid-transfer clears out_valid in the same cycle.
- Addressed routing: mode=0, send 0xA0..0xA3 with dest 0..3, all out_ready=0 -> out_valid=1111, channel k holds 0xAk. Then 0xB1 with dest 1 -> in_ready=0. Pulse out_ready[1] alongside 0xB1 -> accepted, channel 1 = 0xB1, out_valid stays 1111.
- Round-robin fairness: mode=1, out_ready=1111, 8 back-to-back words 0x10..0x17 -> channels 0,1,2,3,0,1,2,3 in order, rr_ptr sequence 1,2,3,0,1,2,3,0, one word per cycle.
- Round-robin skip: mode=1, rr_ptr=1, channels 1 and 2 full, out_ready=0000, send 0x55 -> lands on channel 3, rr_ptr=0. Next word 0x66 -> channel 0, rr_ptr=1. Next word -> in_ready=0.
- Stall stability: channel 2 loaded with 0x3C, out_ready[2]=0 for 5 cycles while other traffic flows -> out_data[2]=0x3C and out_valid[2]=1 throughout. Then out_ready[2]=1 for 1 cycle -> out_valid[2]=0.
- Mode switch: mode=1 with rr_ptr=2, switch to mode=0 and send 0x77 to dest 0 -> channel 0, rr_ptr stays 2. Switch back to mode=1, next word -> channel 2.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// 1-to-4 demux dispatcher: addressed or round-robin routing into four
// one-entry holding slots, each drained by its own valid/ready consumer.
module dispatch_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);
  // load wins over drain so a same-cycle refill keeps the slot valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux_dispatch_ctrl #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [1:0]      in_dest,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*DW-1:0] out_data,
  output logic [1:0]      rr_ptr,
  output logic            busy
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] avail;
  logic [NUM_LANES-1:0] load;
  logic [1:0]           rr_tgt;
  logic [1:0]           target;
  logic                 accept;

  assign avail = ~out_valid | out_ready;

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    rr_tgt = rr_ptr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (avail[rr_ptr + 2'(i)]) rr_tgt = rr_ptr + 2'(i);
    end
  end

  assign target   = mode ? rr_tgt : in_dest;
  assign in_ready = mode ? |avail : avail[in_dest];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) load[target] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_ptr <= 2'd0;
    else if (accept && mode) rr_ptr <= target + 2'd1;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dispatch_slot #(.DW(DW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .data  (out_data[k*DW +: DW])
    );
  end

  assign busy = |out_valid;
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Randomised and directed bench for demux_dispatch_ctrl against a slot-level
// behavioural model of the four holding registers and the search pointer.
module tb_demux_dispatch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [1:0]  rr_ptr;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  bit [3:0]  mv;
  logic [7:0] md [4];
  int        mptr;

  demux_dispatch_ctrl #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Where would the current word go, and can it go anywhere at all?
  function automatic void pred(output bit rdy, output int tgt);
    bit free [4];
    for (int k = 0; k < 4; k++) free[k] = !mv[k] || out_ready[k];
    rdy = 0;
    tgt = in_dest;
    if (mode) begin
      for (int o = 3; o >= 0; o--)
        if (free[(mptr + o) % 4]) begin rdy = 1; tgt = (mptr + o) % 4; end
    end else begin
      rdy = free[in_dest];
    end
  endfunction

  task automatic cycle();
    bit rdy; int tgt;
    pred(rdy, tgt);
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (mv[k] && out_ready[k]) mv[k] = 0;
    if (in_valid && rdy) begin
      mv[tgt] = 1;
      md[tgt] = in_data;
      if (mode) mptr = (tgt + 1) % 4;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] dst,
                       input bit m, input logic [3:0] ordy);
    in_valid = v; in_data = d; in_dest = dst; mode = m; out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mv = 0; mptr = 0;
    for (int k = 0; k < 4; k++) md[k] = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (rr_ptr !== 2'd0) begin n_bad++; $display("FAIL reset_ptr got %0d want 0", rr_ptr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    for (int d = 0; d < 4; d++) begin
      drive(0, 8'h00, 2'(d), 0, 4'b0000);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy_m0 d%0d got %b want 1", d, in_ready); end
    end
    drive(0, 8'h00, 2'd0, 1, 4'b0000);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy_m1 got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 8'h5A, 2'd1, 0, 4'b0000);
    cycle();
    drive(1, 8'h5B, 2'd2, 0, 4'b0000);
    n_cmp++; if (out_valid !== 4'b0010) begin n_bad++; $display("FAIL mid_pre got %b want 0010", out_valid); end
    rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_async got %b want 0000", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_addressed();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'hA0 + 8'(k), 2'(k), 0, 4'b0000);
      cycle();
    end
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    n_cmp++; if (out_valid !== 4'b1111) begin n_bad++; $display("FAIL addr_valid got %b want 1111", out_valid); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_data[k*8 +: 8] !== 8'hA0 + 8'(k)) begin n_bad++; $display("FAIL addr_data ch%0d got %h want %h", k, out_data[k*8 +: 8], 8'hA0 + 8'(k)); end
    end
    drive(1, 8'hB1, 2'd1, 0, 4'b0000);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL addr_full_rdy got %b want 0", in_ready); end
    drive(1, 8'hB1, 2'd1, 1, 4'b0000);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL addr_full_rdy_m1 got %b want 0", in_ready); end
    cycle();
    n_cmp++; if (out_data[15:8] !== 8'hA1) begin n_bad++; $display("FAIL addr_hold got %h want a1", out_data[15:8]); end
    drive(1, 8'hB1, 2'd1, 0, 4'b0010);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL addr_drain_rdy got %b want 1", in_ready); end
    cycle();
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    n_cmp++; if (out_valid !== 4'b1111) begin n_bad++; $display("FAIL addr_refill_valid got %b want 1111", out_valid); end
    n_cmp++; if (out_data[15:8] !== 8'hB1) begin n_bad++; $display("FAIL addr_refill_data got %h want b1", out_data[15:8]); end
  endtask

  task automatic test_rr_fair();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'h10 + 8'(i), 2'd0, 1, 4'b1111);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_rdy w%0d got %b want 1", i, in_ready); end
      cycle();
      n_cmp++; if (out_valid !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL rr_chan w%0d got %b want %b", i, out_valid, 4'(1 << (i % 4))); end
      n_cmp++; if (out_data[(i%4)*8 +: 8] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL rr_data w%0d got %h want %h", i, out_data[(i%4)*8 +: 8], 8'h10 + 8'(i)); end
      n_cmp++; if (rr_ptr !== 2'((i + 1) % 4)) begin n_bad++; $display("FAIL rr_ptr w%0d got %0d want %0d", i, rr_ptr, (i + 1) % 4); end
    end
  endtask

  task automatic test_rr_skip();
    do_reset();
    drive(1, 8'h01, 2'd1, 0, 4'b0000); cycle();
    drive(1, 8'h02, 2'd2, 0, 4'b0000); cycle();
    drive(1, 8'h03, 2'd0, 1, 4'b0000); cycle();
    drive(0, 8'h00, 2'd0, 1, 4'b0001); cycle();
    drive(0, 8'h00, 2'd0, 1, 4'b0000);
    n_cmp++; if (rr_ptr !== 2'd1 || out_valid !== 4'b0110) begin n_bad++; $display("FAIL skip_setup got ptr %0d valid %b want 1 0110", rr_ptr, out_valid); end
    drive(1, 8'h55, 2'd0, 1, 4'b0000); cycle();
    n_cmp++; if (out_valid !== 4'b1110 || out_data[31:24] !== 8'h55) begin n_bad++; $display("FAIL skip_55 got %b %h want 1110 55", out_valid, out_data[31:24]); end
    n_cmp++; if (rr_ptr !== 2'd0) begin n_bad++; $display("FAIL skip_ptr0 got %0d want 0", rr_ptr); end
    drive(1, 8'h66, 2'd0, 1, 4'b0000); cycle();
    n_cmp++; if (out_valid !== 4'b1111 || out_data[7:0] !== 8'h66) begin n_bad++; $display("FAIL skip_66 got %b %h want 1111 66", out_valid, out_data[7:0]); end
    n_cmp++; if (rr_ptr !== 2'd1) begin n_bad++; $display("FAIL skip_ptr1 got %0d want 1", rr_ptr); end
    drive(1, 8'h77, 2'd0, 1, 4'b0000);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL skip_full got %b want 0", in_ready); end
    cycle();
    n_cmp++; if (rr_ptr !== 2'd1) begin n_bad++; $display("FAIL skip_noacc_ptr got %0d want 1", rr_ptr); end
  endtask

  task automatic test_stall();
    logic [1:0] dst;
    do_reset();
    drive(1, 8'h3C, 2'd2, 0, 4'b0000); cycle();
    for (int i = 0; i < 5; i++) begin
      dst = 2'($urandom_range(0, 1));
      if (dst == 2'd1) dst = 2'd3;
      drive(1, 8'($urandom), dst, 0, {$urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1});
      cycle();
      n_cmp++; if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h3C) begin n_bad++; $display("FAIL stall c%0d got %b %h want 1 3c", i, out_valid[2], out_data[23:16]); end
      n_cmp++; if (out_valid !== 4'(mv)) begin n_bad++; $display("FAIL stall_model c%0d got %b want %b", i, out_valid, mv); end
    end
    drive(0, 8'h00, 2'd0, 0, 4'b0100); cycle();
    n_cmp++; if (out_valid[2] !== 1'b0 || out_data[23:16] !== 8'h3C) begin n_bad++; $display("FAIL stall_drain got %b %h want 0 3c", out_valid[2], out_data[23:16]); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    drive(1, 8'h21, 2'd0, 1, 4'b1111); cycle();
    drive(1, 8'h22, 2'd0, 1, 4'b1111); cycle();
    drive(0, 8'h00, 2'd0, 1, 4'b1111); cycle();
    n_cmp++; if (rr_ptr !== 2'd2) begin n_bad++; $display("FAIL ms_setup got %0d want 2", rr_ptr); end
    drive(1, 8'h77, 2'd0, 0, 4'b0000); cycle();
    n_cmp++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h77) begin n_bad++; $display("FAIL ms_m0 got %b %h want 0001 77", out_valid, out_data[7:0]); end
    n_cmp++; if (rr_ptr !== 2'd2) begin n_bad++; $display("FAIL ms_ptr got %0d want 2", rr_ptr); end
    drive(1, 8'h88, 2'd0, 1, 4'b0000); cycle();
    n_cmp++; if (out_valid !== 4'b0101 || out_data[23:16] !== 8'h88) begin n_bad++; $display("FAIL ms_m1 got %b %h want 0101 88", out_valid, out_data[23:16]); end
    n_cmp++; if (rr_ptr !== 2'd3) begin n_bad++; $display("FAIL ms_ptr2 got %0d want 3", rr_ptr); end
  endtask

  task automatic test_random();
    bit rdy; int tgt;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), $urandom_range(0, 1) == 1, 4'($urandom));
      pred(rdy, tgt);
      n_cmp++; if (in_ready !== rdy) begin n_bad++; $display("FAIL rnd_rdy c%0d got %b want %b", i, in_ready, rdy); end
      cycle();
      n_cmp++; if (out_valid !== 4'(mv) || rr_ptr !== 2'(mptr) || busy !== (mv != 0)) begin
        n_bad++; $display("FAIL rnd_state c%0d got v%b p%0d b%b want v%b p%0d", i, out_valid, rr_ptr, busy, mv, mptr);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (out_data[k*8 +: 8] !== md[k]) begin n_bad++; $display("FAIL rnd_data c%0d ch%0d got %h want %h", i, k, out_data[k*8 +: 8], md[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_addressed();
    test_rr_fair();
    test_rr_skip();
    test_stall();
    test_mode_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
